// File: rtl/tensor_core_pkg.sv
// Shared definitions for the instruction stream unit: word layout, HALT encoding
// and the streaming FSM state type.
package tensor_core_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int OPCODE_MSB  = 31;
    localparam int OPCODE_LSB  = 24;

    localparam logic [7:0] HALT_OPCODE = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } stream_state_t;

    function automatic logic is_halt(input logic [INSTR_WIDTH-1:0] word);
        return word[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/instruction_stream_if.sv
// Program-load, control and CPU-facing instruction handshake bundle.
// Handshake: a word transfers on every rising edge where instruction_valid_out and
// instruction_ready_in are both high; while valid is high and ready is low, the
// producer holds instruction_out and pc_out stable and keeps valid asserted.
interface instruction_stream_if
#(
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
);
    import tensor_core_pkg::*;

    logic                   load_enable_in;
    logic [ADDR_WIDTH-1:0]  load_address_in;
    logic [INSTR_WIDTH-1:0] load_data_in;
    logic [ADDR_WIDTH:0]    program_length_in;
    logic                   start_in;
    logic [INSTR_WIDTH-1:0] instruction_out;
    logic                   instruction_valid_out;
    logic                   instruction_ready_in;
    logic [ADDR_WIDTH-1:0]  pc_out;
    logic                   busy_out;
    logic                   done_out;
    stream_state_t          state_dbg;

    modport master (
        input  load_enable_in, load_address_in, load_data_in, program_length_in,
        input  start_in, instruction_ready_in,
        output instruction_out, instruction_valid_out, pc_out, busy_out, done_out,
        output state_dbg
    );

    modport slave (
        output load_enable_in, load_address_in, load_data_in, program_length_in,
        output start_in, instruction_ready_in,
        input  instruction_out, instruction_valid_out, pc_out, busy_out, done_out,
        input  state_dbg
    );

endinterface

// File: rtl/instruction_stream_unit_program_memory.sv
// Program store: one write port, one synchronous read port with 1-cycle latency.
// The array has no reset so programs survive across runs and resets.
module program_memory
#(
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int DATA_WIDTH = 32
)
(
    input  logic                  clk,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[write_address] <= write_data;
        end
        if (read_enable) begin
            read_data <= mem[read_address];
        end
    end

endmodule

// File: rtl/instruction_stream_unit.sv
// Streams program words to the CPU: FSM, read issue control and a 2-entry output
// buffer in front of the synchronous program memory.
module instruction_stream_unit
    import tensor_core_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
)
(
    input  logic                 clock_in,
    input  logic                 reset_n_in,
    instruction_stream_if.master bus
);

    localparam int                  LW        = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LEN = LW'(DEPTH);

    stream_state_t state, next_state;

    logic [ADDR_WIDTH:0]    length_q;
    logic [ADDR_WIDTH:0]    issued_q;
    logic                   inflight_q;
    logic [ADDR_WIDTH-1:0]  inflight_pc_q;
    logic [INSTR_WIDTH-1:0] rd_data;

    logic [INSTR_WIDTH-1:0] buf_instr [2];
    logic [ADDR_WIDTH-1:0]  buf_pc    [2];
    logic                   head_q;
    logic                   tail_q;
    logic [1:0]             count_q;

    logic                   start_accept;
    logic [ADDR_WIDTH:0]    clamped_len;
    logic                   pop;
    logic                   push;
    logic                   halt_arrival;
    logic [2:0]             level;
    logic                   issue;

    assign start_accept = (state == ST_IDLE) && bus.start_in;
    assign clamped_len  = (bus.program_length_in > DEPTH_LEN) ? DEPTH_LEN : bus.program_length_in;

    assign pop          = (count_q != 2'd0) && bus.instruction_ready_in;
    assign push         = inflight_q;
    assign halt_arrival = inflight_q && is_halt(rd_data);

    // Projected occupancy after this cycle's pop; keeps buffer + pending read within 2.
    assign level = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue = (state == ST_FETCH) && (issued_q != length_q) && !halt_arrival
                   && (level < 3'd2);

    program_memory #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (INSTR_WIDTH)
    ) u_program_memory (
        .clk           (clock_in),
        .write_enable  ((state == ST_IDLE) && bus.load_enable_in),
        .write_address (bus.load_address_in),
        .write_data    (bus.load_data_in),
        .read_enable   (issue),
        .read_address  (issued_q[ADDR_WIDTH-1:0]),
        .read_data     (rd_data)
    );

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (start_accept) begin
                    next_state = (clamped_len == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if ((issue && (issued_q + LW'(1) == length_q)) || halt_arrival) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            length_q      <= '0;
            issued_q      <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            if (start_accept) begin
                length_q <= clamped_len;
                issued_q <= '0;
            end else if (issue) begin
                issued_q <= issued_q + LW'(1);
            end
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= issued_q[ADDR_WIDTH-1:0];
            end
        end
    end

    // Entries are cleared on reset so the head presents zeros until the first push.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            buf_instr[0] <= '0;
            buf_instr[1] <= '0;
            buf_pc[0]    <= '0;
            buf_pc[1]    <= '0;
            head_q       <= 1'b0;
            tail_q       <= 1'b0;
            count_q      <= 2'd0;
        end else begin
            if (push) begin
                buf_instr[tail_q] <= rd_data;
                buf_pc[tail_q]    <= inflight_pc_q;
                tail_q            <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus.instruction_out       = buf_instr[head_q];
    assign bus.pc_out                = buf_pc[head_q];
    assign bus.instruction_valid_out = (count_q != 2'd0);
    assign bus.busy_out              = (state == ST_FETCH) || (state == ST_DRAIN);
    assign bus.done_out              = (state == ST_DONE);
    assign bus.state_dbg             = state;

endmodule

// File: tb/tb_instruction_stream_unit.sv
// Directed bench for instruction_stream_unit: loads programs, streams them under
// several ready patterns and checks words, addresses, handshake timing and control.
module tb_instruction_stream_unit;
    import tensor_core_pkg::*;

    localparam int DEPTH = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_pc_q[$];

    instruction_stream_if #(.DEPTH(DEPTH)) bus();

    instruction_stream_unit #(.DEPTH(DEPTH)) dut (
        .clock_in   (clk),
        .reset_n_in (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] addr, input logic [31:0] data);
        bus.load_enable_in  = 1'b1;
        bus.load_address_in = addr;
        bus.load_data_in    = data;
        tick();
        bus.load_enable_in  = 1'b0;
    endtask

    task automatic start_run(input logic [8:0] len);
        bus.program_length_in = len;
        bus.start_in          = 1'b1;
        tick();
        bus.start_in          = 1'b0;
    endtask

    task automatic expect_word(input logic [31:0] word, input logic [31:0] pc);
        exp_q.push_back(word);
        exp_pc_q.push_back(pc);
    endtask

    task automatic expect_prog(input int n);
        for (int i = 0; i < n; i++) begin
            expect_word(32'h0100_0001 + 32'(i), 32'(i));
        end
    endtask

    // Consumes the expected queue; toggle selects the 1,0,0 ready pattern.
    task automatic run_stream(input bit toggle, output int cycles);
        bit          last_acc = 1'b0;
        bit          finished = 1'b0;
        bit          held     = 1'b0;
        bit          rdy;
        logic [31:0] held_instr = '0;
        logic [31:0] held_pc    = '0;
        logic [31:0] e;
        logic [31:0] epc;
        cycles = 0;
        for (int k = 0; k < 300 && !finished; k++) begin
            tick();
            cycles++;
            if (last_acc) begin
                check("done_pulse", 32'(bus.done_out), 32'd1);
                check("busy_at_done", 32'(bus.busy_out), 32'd0);
                check("valid_after_last", 32'(bus.instruction_valid_out), 32'd0);
                finished = 1'b1;
            end else begin
                if (bus.done_out) check("done_early", 32'(bus.done_out), 32'd0);
                if (held) begin
                    check("hold_instr", bus.instruction_out, held_instr);
                    check("hold_pc", 32'(bus.pc_out), held_pc);
                end
                rdy = toggle ? ((k % 3) == 0) : 1'b1;
                bus.instruction_ready_in = rdy;
                if (bus.instruction_valid_out && rdy) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("extra_word", 32'(bus.instruction_valid_out), 32'd0);
                    end else begin
                        e   = exp_q.pop_front();
                        epc = exp_pc_q.pop_front();
                        check("word", bus.instruction_out, e);
                        check("pc", 32'(bus.pc_out), epc);
                        if (exp_q.size() == 0) last_acc = 1'b1;
                    end
                end else begin
                    held       = bus.instruction_valid_out;
                    held_instr = bus.instruction_out;
                    held_pc    = 32'(bus.pc_out);
                end
            end
        end
        check("stream_finished", 32'(finished), 32'd1);
        exp_q.delete();
        exp_pc_q.delete();
        bus.instruction_ready_in = 1'b1;
        tick();
        check("done_cleared", 32'(bus.done_out), 32'd0);
    endtask

    initial begin
        int cycles;
        int acc;

        bus.load_enable_in       = 1'b0;
        bus.load_address_in      = '0;
        bus.load_data_in         = '0;
        bus.program_length_in    = '0;
        bus.start_in             = 1'b0;
        bus.instruction_ready_in = 1'b1;

        // Reset values
        #12;
        check("rst_instr", bus.instruction_out, 32'h0);
        check("rst_valid", 32'(bus.instruction_valid_out), 32'd0);
        check("rst_pc", 32'(bus.pc_out), 32'd0);
        check("rst_busy", 32'(bus.busy_out), 32'd0);
        check("rst_done", 32'(bus.done_out), 32'd0);
        check("rst_state", 32'(bus.state_dbg), 32'(ST_IDLE));
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            load_word(8'(i), 32'h0100_0001 + 32'(i));
        end

        // Ready always high: latency two edges, then five back-to-back words
        start_run(9'd5);
        check("start_busy", 32'(bus.busy_out), 32'd1);
        check("start_valid_n", 32'(bus.instruction_valid_out), 32'd0);
        tick();
        check("start_valid_n1", 32'(bus.instruction_valid_out), 32'd0);
        expect_prog(5);
        run_stream(1'b0, cycles);
        check("throughput_cycles", 32'(cycles), 32'd6);

        // Backpressure with ready 1,0,0,...
        start_run(9'd5);
        expect_prog(5);
        run_stream(1'b1, cycles);

        // Write and start in the same IDLE cycle: the new word is streamed
        bus.load_enable_in    = 1'b1;
        bus.load_address_in   = 8'd0;
        bus.load_data_in      = 32'h0200_0000;
        bus.program_length_in = 9'd1;
        bus.start_in          = 1'b1;
        tick();
        bus.load_enable_in    = 1'b0;
        bus.start_in          = 1'b0;
        expect_word(32'h0200_0000, 32'd0);
        run_stream(1'b0, cycles);
        load_word(8'd0, 32'h0100_0001);

        // HALT at address 2 ends the run after three words
        load_word(8'd2, 32'hFF00_0000);
        start_run(9'd5);
        expect_word(32'h0100_0001, 32'd0);
        expect_word(32'h0100_0002, 32'd1);
        expect_word(32'hFF00_0000, 32'd2);
        run_stream(1'b0, cycles);
        load_word(8'd2, 32'h0100_0003);

        // Length zero: straight to DONE, never busy
        start_run(9'd0);
        check("len0_done", 32'(bus.done_out), 32'd1);
        check("len0_busy", 32'(bus.busy_out), 32'd0);
        check("len0_valid", 32'(bus.instruction_valid_out), 32'd0);
        tick();
        check("len0_done_clear", 32'(bus.done_out), 32'd0);
        check("len0_busy_after", 32'(bus.busy_out), 32'd0);

        // Asynchronous reset after the second word is accepted
        start_run(9'd5);
        acc = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (acc == 2) break;
            if (bus.instruction_valid_out) acc++;
        end
        check("pre_reset_accepted", 32'(acc), 32'd2);
        check("pre_reset_valid", 32'(bus.instruction_valid_out), 32'd1);
        check("pre_reset_pc", 32'(bus.pc_out), 32'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_instr", bus.instruction_out, 32'h0);
        check("mid_rst_valid", 32'(bus.instruction_valid_out), 32'd0);
        check("mid_rst_pc", 32'(bus.pc_out), 32'd0);
        check("mid_rst_busy", 32'(bus.busy_out), 32'd0);
        check("mid_rst_done", 32'(bus.done_out), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        start_run(9'd5);
        expect_prog(5);
        run_stream(1'b0, cycles);

        // Load and start while busy are both ignored
        bus.instruction_ready_in = 1'b0;
        start_run(9'd5);
        bus.load_enable_in    = 1'b1;
        bus.load_address_in   = 8'd1;
        bus.load_data_in      = 32'hDEAD_BEEF;
        bus.program_length_in = 9'd2;
        bus.start_in          = 1'b1;
        tick();
        bus.load_enable_in    = 1'b0;
        bus.start_in          = 1'b0;
        check("busy_ignore", 32'(bus.busy_out), 32'd1);
        expect_prog(5);
        run_stream(1'b0, cycles);
        start_run(9'd2);
        expect_prog(2);
        run_stream(1'b0, cycles);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
